// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recoded digits
// and the three-bit window to digit recoding function.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        DZERO,
        DPOS1,
        DPOS2,
        DNEG1,
        DNEG2
    } digit_t;

    // Window is {y[2i+1], y[2i], y[2i-1]}.
    function automatic digit_t booth_digit(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = DPOS1;
            3'b011:         d = DPOS2;
            3'b100:         d = DNEG2;
            3'b101, 3'b110: d = DNEG1;
            default:        d = DZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product selector: maps a recoded digit and the extended
// multiplicand onto an accumulator-width addend plus a carry-in for negation.
module booth_r4_pp
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  digit_t             digit,
    input  logic [WIDTH+1:0]   x_ext,
    output logic [WIDTH+3:0]   addend,
    output logic               cin
);

    localparam int E = WIDTH + 2;

    logic [WIDTH+3:0] x1;
    logic [WIDTH+3:0] x2;

    assign x1 = {{2{x_ext[E-1]}}, x_ext};
    assign x2 = {x_ext[E-1], x_ext, 1'b0};

    // Negative digits reuse the accumulator adder: ~v plus carry-in equals -v.
    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (digit)
            DPOS1: addend = x1;
            DPOS2: addend = x2;
            DNEG1: begin
                addend = ~x1;
                cin    = 1'b1;
            end
            DNEG2: begin
                addend = ~x2;
                cin    = 1'b1;
            end
            default: begin
                addend = '0;
                cin    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define MUL_SAT_EN to saturate result on overflow; otherwise result wraps.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 ov,
    output state_t               state
);

    localparam int E  = WIDTH + 2;
    localparam int A  = WIDTH + 4;
    localparam int D  = WIDTH / 2 + 1;
    localparam int CW = $clog2(D + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and in_ready may depend on out_ready.
    state_t             state_next;
    logic               accept;
    logic               last;
    logic [CW-1:0]      cnt;
    logic               sgn_reg;
    logic [E-1:0]       x_reg;
    logic [A-1:0]       acc;
    logic [E-1:0]       ysh;
    logic               yprev;
    digit_t             digit;
    logic [A-1:0]       addend;
    logic               cin;
    logic [A-1:0]       acc_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic               ov_next;
    logic [WIDTH-1:0]   result_next;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(D - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (last) state_next = DONE;
            DONE: if (out_ready) state_next = in_valid ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign digit = booth_digit({ysh[1:0], yprev});

    booth_r4_pp #(.WIDTH(WIDTH)) u_pp (
        .digit  (digit),
        .x_ext  (x_reg),
        .addend (addend),
        .cin    (cin)
    );

    assign acc_sum = acc + addend + {{(A-1){1'b0}}, cin};

    // Low 2W bits of {acc, y} after the final two-bit shift.
    assign prod_next = {acc_sum[WIDTH-1:0], ysh[E-1:2]};

    always_comb begin
        if (sgn_reg)
            ov_next = !((&prod_next[2*WIDTH-1:WIDTH-1]) || !(|prod_next[2*WIDTH-1:WIDTH-1]));
        else
            ov_next = |prod_next[2*WIDTH-1:WIDTH];
    end

`ifdef MUL_SAT_EN
    logic [WIDTH-1:0] sat_val;
    always_comb begin
        if (!sgn_reg)
            sat_val = '1;
        else if (prod_next[2*WIDTH-1])
            sat_val = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end
    assign result_next = ov_next ? sat_val : prod_next[WIDTH-1:0];
`else
    assign result_next = prod_next[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sgn_reg <= 1'b0;
            x_reg   <= '0;
            acc     <= '0;
            ysh     <= '0;
            yprev   <= 1'b0;
            product <= '0;
            result  <= '0;
            ov      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                sgn_reg <= sgn;
                x_reg   <= {{2{sgn & x[WIDTH-1]}}, x};
                ysh     <= {{2{sgn & y[WIDTH-1]}}, y};
                yprev   <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
            end else if (state == CALC) begin
                acc   <= {{2{acc_sum[A-1]}}, acc_sum[A-1:2]};
                ysh   <= {acc_sum[1:0], ysh[E-1:2]};
                yprev <= ysh[1];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    product <= prod_next;
                    result  <= result_next;
                    ov      <= ov_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WIDTH=16 and WIDTH=8.
module tb_booth_mul_seq;
    import booth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, sgn, out_valid, out_ready, ov;
    logic [15:0] x, y, result;
    logic [31:0] product;
    state_t      st;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, ov8;
    logic [7:0]  x8, y8, result8;
    logic [15:0] product8;
    state_t      st8;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sgn(sgn),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .result(result), .ov(ov), .state(st)
    );

    booth_mul_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .sgn(sgn8),
        .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .result(result8), .ov(ov8), .state(st8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] res16(input logic s, input logic [31:0] p, input logic o);
`ifdef MUL_SAT_EN
        if (o) return s ? (p[31] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
        return p[15:0];
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic start16(input logic s, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1; sgn = s; x = a; y = b;
        #1;
        chk("accept_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); sgn = 1'($urandom);
    endtask

    task automatic wait16(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take16();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic op16(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] ep, input logic eo);
        int lat;
        start16(s, a, b);
        wait16(lat);
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_product"}, product, ep);
        chk({tag, "_result"}, result, res16(s, ep, eo));
        chk({tag, "_ov"}, ov, eo);
        take16();
    endtask

    initial begin
        int lat;
        logic [31:0] hold_p;
        logic signed [31:0] ps;
        logic [31:0] pu;
        logic [15:0] a, b;
        logic eo;

        rst = 1'b1;
        in_valid = 0; sgn = 0; x = 0; y = 0; out_ready = 0;
        in_valid8 = 0; sgn8 = 0; x8 = 0; y8 = 0; out_ready8 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_state", st, IDLE);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_product", product, 32'h0);
        chk("rst_result", result, 16'h0);
        chk("rst_ov", ov, 1'b0);
        @(negedge clk);

        op16("t1", 1'b1, 16'd3, 16'hFFFB, 32'hFFFFFFF1, 1'b0);
        op16("t2", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
        op16("t3", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
        op16("t3b", 1'b0, 16'd300, 16'd200, 32'd60000, 1'b0);
        op16("t3c", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b1);

        // Backpressure: 100 * -3 held in DONE.
        start16(1'b1, 16'd100, 16'hFFFD);
        wait16(lat);
        chk("t4_lat", lat, 10);
        chk("t4_product", product, 32'hFFFFFED4);
        hold_p = product;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_in_ready", in_ready, 1'b0);
            chk("t4_hold_product", product, hold_p);
            chk("t4_hold_result", result, 16'hFED4);
        end
        out_ready = 1'b1;
        start16(1'b1, 16'd7, 16'd6);
        out_ready = 1'b0;
        #1;
        chk("t4_b2b_state", st, CALC);
        wait16(lat);
        chk("t4_b2b_lat", lat, 10);
        chk("t4_b2b_product", product, 32'd42);
        chk("t4_b2b_ov", ov, 1'b0);
        take16();

        // Reset in the middle of a calculation.
        start16(1'b1, 16'd1234, 16'd567);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_product", product, 32'h0);
        chk("t5_result", result, 16'h0);
        chk("t5_ov", ov, 1'b0);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        chk("t5_no_emit", lat, 0);
        op16("t5_after", 1'b1, 16'd2, 16'hFFFE, 32'hFFFFFFFC, 1'b0);

        // WIDTH=8: -128 * 127.
        in_valid8 = 1'b1; sgn8 = 1'b1; x8 = 8'h80; y8 = 8'h7F;
        #1;
        chk("t6_accept", in_ready8, 1'b1);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_lat", lat, 6);
        chk("t6_product", product8, 16'hC080);
        chk("t6_ov", ov8, 1'b1);
        chk("t6_result", result8, 8'h80);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        in_valid8 = 1'b1; sgn8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t6u_product", product8, 16'hFE01);
        chk("t6u_ov", ov8, 1'b1);
`ifdef MUL_SAT_EN
        chk("t6u_result", result8, 8'hFF);
`else
        chk("t6u_result", result8, 8'h01);
`endif
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;

        // Random operands against the simulator's own multiply, both modes.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 200; i++) begin
                a = 16'($urandom_range(0, 65535));
                b = 16'($urandom_range(0, 65535));
                if (m == 1) begin
                    ps = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
                    eo = (ps > 32'sd32767) || (ps < -32'sd32768);
                    op16("rnd_s", 1'b1, a, b, ps, eo);
                end else begin
                    pu = {16'h0, a} * {16'h0, b};
                    eo = (pu[31:16] != 16'h0);
                    op16("rnd_u", 1'b0, a, b, pu, eo);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
